// File: rtl/button_input_pkg.sv
// rtl/button_input_pkg.sv - shared constants and status-word packing for button_input
//
// Purpose: SoC-level constants for the button block (register field offsets,
//          write-1-to-clear bit offsets, default debounce time) and a helper
//          that assembles the 32-bit status word.
// Contents:
//   STABLE_LSB / PRESS_LSB / RELEASE_LSB   rdata field offsets
//   PRESS_CLR_LSB / RELEASE_CLR_LSB        wdata clear-mask offsets
//   DEBOUNCE_CYCLES_DEFAULT                stable time in clk cycles
//   pack_status()                          builds rdata from the three fields

package button_input_pkg;

  localparam int STABLE_LSB  = 0;
  localparam int PRESS_LSB   = 4;
  localparam int RELEASE_LSB = 8;

  localparam int PRESS_CLR_LSB   = 0;
  localparam int RELEASE_CLR_LSB = 4;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Fields are zero-extended to 8 bits by the caller; unused bits stay 0.
  function automatic logic [31:0] pack_status(input logic [7:0] stb,
                                              input logic [7:0] prs,
                                              input logic [7:0] rel);
    logic [31:0] word;
    word = ({24'h0, stb} << STABLE_LSB)
         | ({24'h0, prs} << PRESS_LSB)
         | ({24'h0, rel} << RELEASE_LSB);
    return word;
  endfunction

endpackage

// File: rtl/button_input_if.sv
// rtl/button_input_if.sv - register bus interface for button_input
//
// Purpose: groups the simple strobe-based register bus.
// Signals:
//   wdata [7:0]  write data (flag clear masks)
//   sel          device select
//   wstrb        write strobe
//   rstrb        read strobe (no side effects)
//   rdata [31:0] read data, driven by the slave
// Modports: master (bus initiator), slave (button_input)

interface button_input_if;
  logic [7:0]  wdata;
  logic        sel;
  logic        wstrb;
  logic        rstrb;
  logic [31:0] rdata;

  modport master (output wdata, output sel, output wstrb, output rstrb, input rdata);
  modport slave  (input wdata, input sel, input wstrb, input rstrb, output rdata);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchronizer, debounce counter and edge pulses
//
// Purpose: brings one asynchronous pin into the clk domain and only accepts a
//          new level after it has been seen DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   btn_raw  asynchronous pin
//   stable   debounced level
//   rise     one-cycle high on the edge where stable goes 0->1
//   fall     one-cycle high on the edge where stable goes 1->0

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             settle;

  assign differ = sync2 ^ stable;
  // settle is the edge on which stable takes the new level.
  assign settle = differ && (cnt == CNT_MAX);

  // Pulses come from registered state only, so the flag logic never sees BTN directly.
  assign rise = settle & sync2;
  assign fall = settle & ~sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (!differ) begin
        // Any agreement, including a pin that bounced back, restarts the count.
        cnt <= '0;
      end else if (settle) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_input.sv
// rtl/button_input.sv - debounced button inputs with press/release flags and irq
//
// Purpose: one btn_debounce per pin; sticky press/release flags cleared by
//          write-1-to-clear; status readable over the register bus.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    register bus (slave): wdata/sel/wstrb/rstrb in, rdata out
//   BTN    raw asynchronous pins, active-high
//   irq    high while any press or release flag is set

module button_input
  import button_input_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  button_input_if.slave      bus,
  input  logic [N_BTN-1:0]   BTN,
  output logic               irq
);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] press_flag;
  logic [N_BTN-1:0] rel_flag;
  logic [N_BTN-1:0] clr_press;
  logic [N_BTN-1:0] clr_rel;
  logic [15:0]      wdata_ext;
  logic             wr_en;
  logic             unused_bus;

  // Widened so release-clear indices past bit 7 read as 0 rather than out of range.
  assign wdata_ext = {8'h00, bus.wdata};
  assign wr_en     = bus.sel & bus.wstrb;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(BTN[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );

    assign clr_press[i] = wr_en & wdata_ext[PRESS_CLR_LSB + i];
    assign clr_rel[i]   = wr_en & wdata_ext[RELEASE_CLR_LSB + i];
  end

  // A new edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_flag <= '0;
      rel_flag   <= '0;
    end else begin
      press_flag <= rise | (press_flag & ~clr_press);
      rel_flag   <= fall | (rel_flag & ~clr_rel);
    end
  end

  assign irq = (|press_flag) | (|rel_flag);

  assign bus.rdata = bus.sel ? pack_status(8'(stable), 8'(press_flag), 8'(rel_flag))
                             : 32'h0000_0000;

  // Reads have no side effects; rstrb and spare wdata bits are intentionally ignored.
  assign unused_bus = ^{bus.rstrb, wdata_ext};

endmodule

// File: tb/tb_button_input.sv
// tb/tb_button_input.sv - self-checking bench for button_input

module tb_button_input;

  localparam int D = 4;
  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] BTN;
  logic         irq;

  button_input_if bus();

  button_input #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .BTN  (BTN),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pin samples per edge, and a level flips once the
  // synchronized view (two edges late) has disagreed for D straight edges
  // since the last flip or reset.
  int       t = 10;
  bit [3:0] hist [256];
  bit [3:0] m_stable = '0;
  bit [3:0] m_press  = '0;
  bit [3:0] m_rel    = '0;
  int       last_flip [4];

  function automatic logic [31:0] exp_rdata();
    if (!bus.sel) return 32'h0;
    return {20'h0, m_rel, m_press, m_stable};
  endfunction

  task automatic tick();
    bit [3:0] rose;
    bit [3:0] fell;
    bit [7:0] wmask;
    bit       ok;
    @(posedge clk);
    t++;
    if (reset) begin
      m_stable = '0;
      m_press  = '0;
      m_rel    = '0;
      for (int b = 0; b < 4; b++) last_flip[b] = t;
      hist[t % 256]       = '0;
      hist[(t - 1) % 256] = '0;
    end else begin
      rose = '0;
      fell = '0;
      for (int b = 0; b < 4; b++) begin
        if (t - last_flip[b] >= D) begin
          ok = 1'b1;
          for (int j = 0; j < D; j++)
            if (hist[(t - 2 - j) % 256][b] == m_stable[b]) ok = 1'b0;
          if (ok) begin
            if (m_stable[b]) fell[b] = 1'b1;
            else rose[b] = 1'b1;
            m_stable[b] = ~m_stable[b];
            last_flip[b] = t;
          end
        end
      end
      hist[t % 256] = BTN;
      wmask   = (bus.sel && bus.wstrb) ? bus.wdata : 8'h00;
      m_press = rose | (m_press & ~wmask[3:0]);
      m_rel   = fell | (m_rel & ~wmask[7:4]);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    BTN = '0;
    bus.sel = 1'b1;
    bus.wstrb = 1'b0;
    bus.rstrb = 1'b0;
    bus.wdata = 8'h00;
    tick();
    tick();
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    reset = 1'b0;
  endtask

  task automatic test_press();
    BTN = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (k < 6 && bus.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL press_early_e%0d: got %h expected 00000000", k, bus.rdata);
      end else if (k == 6 && bus.rdata !== 32'h11) begin
        n_fail++;
        $display("FAIL press_rdata: got %h expected 00000011", bus.rdata);
      end
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL press_irq: got %b expected 1", irq);
    end
  endtask

  task automatic test_glitch();
    BTN = 4'b0011;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) BTN = 4'b0001;
      tick();
      n_checks++;
      if (bus.rdata !== 32'h11 || irq !== 1'b1) begin
        n_fail++;
        $display("FAIL glitch_c%0d: got rdata=%h irq=%b expected 00000011 1", k, bus.rdata, irq);
      end
    end
  endtask

  task automatic test_clear();
    bus.sel = 1'b0;
    bus.wstrb = 1'b1;
    bus.wdata = 8'h01;
    tick();
    bus.wstrb = 1'b0;
    bus.sel = 1'b1;
    #1;
    n_checks++;
    if (bus.rdata !== 32'h11 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_unselected: got rdata=%h irq=%b expected 00000011 1", bus.rdata, irq);
    end
    bus.wstrb = 1'b1;
    tick();
    bus.wstrb = 1'b0;
    n_checks++;
    if (bus.rdata[4] !== 1'b0 || bus.rdata !== 32'h01 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_press: got rdata=%h irq=%b expected 00000001 0", bus.rdata, irq);
    end
  endtask

  task automatic test_release_collision();
    BTN = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        bus.wdata = 8'h10;
        bus.wstrb = 1'b1;
      end
      tick();
      if (k == 5) begin
        n_checks++;
        if (bus.rdata !== 32'h01) begin
          n_fail++;
          $display("FAIL release_early: got %h expected 00000001", bus.rdata);
        end
      end
    end
    bus.wstrb = 1'b0;
    n_checks++;
    if (bus.rdata !== 32'h100 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL release_set_wins: got rdata=%h irq=%b expected 00000100 1", bus.rdata, irq);
    end
    bus.wstrb = 1'b1;
    tick();
    bus.wstrb = 1'b0;
    n_checks++;
    if (bus.rdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL release_clear: got rdata=%h irq=%b expected 00000000 0", bus.rdata, irq);
    end
  endtask

  task automatic test_multi();
    BTN = 4'b1111;
    for (int k = 1; k <= 6; k++) tick();
    n_checks++;
    if (bus.rdata !== 32'hFF || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_press: got rdata=%h irq=%b expected 000000ff 1", bus.rdata, irq);
    end
    bus.wdata = 8'hFF;
    bus.wstrb = 1'b1;
    tick();
    bus.wstrb = 1'b0;
    BTN = 4'b0000;
    for (int k = 1; k <= 6; k++) tick();
    n_checks++;
    if (bus.rdata !== 32'hF00 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_release: got rdata=%h irq=%b expected 00000f00 1", bus.rdata, irq);
    end
    bus.wdata = 8'hF0;
    bus.wstrb = 1'b1;
    tick();
    bus.wstrb = 1'b0;
    n_checks++;
    if (bus.rdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_clear: got rdata=%h irq=%b expected 00000000 0", bus.rdata, irq);
    end
  endtask

  task automatic test_reset_mid();
    BTN = 4'b0001;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.rdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_cleared: got rdata=%h irq=%b expected 00000000 0", bus.rdata, irq);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (k < 6 && bus.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL midreset_early_e%0d: got %h expected 00000000", k, bus.rdata);
      end else if (k == 6 && (bus.rdata !== 32'h11 || irq !== 1'b1)) begin
        n_fail++;
        $display("FAIL midreset_press: got rdata=%h irq=%b expected 00000011 1", bus.rdata, irq);
      end
    end
  endtask

  task automatic test_random();
    int hold [4];
    logic [31:0] exp;
    for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 8);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] == 0) begin
          BTN[b] = ~BTN[b];
          hold[b] = $urandom_range(1, 9);
        end
      end
      bus.sel   = ($urandom_range(0, 3) != 0);
      bus.wstrb = ($urandom_range(0, 3) == 0);
      bus.rstrb = ($urandom_range(0, 1) == 0);
      bus.wdata = 8'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
      exp = exp_rdata();
      n_checks++;
      if (bus.rdata !== exp) begin
        n_fail++;
        $display("FAIL random_rdata_c%0d: got %h expected %h", c, bus.rdata, exp);
      end
      n_checks++;
      if (irq !== (|{m_press, m_rel})) begin
        n_fail++;
        $display("FAIL random_irq_c%0d: got %b expected %b", c, irq, |{m_press, m_rel});
      end
    end
    reset = 1'b0;
    bus.wstrb = 1'b0;
    bus.rstrb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_clear();
    test_release_collision();
    test_multi();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_input.md
BUTTON_INPUT -- requirements
Module: button_input

Interface
REQ-001 SHALL have parameter N_BTN, default 4, giving the number of button inputs (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable-time in clk cycles (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wdata  input  8  write data; bits used for flag clearing.
REQ-006 SHALL have port sel  input  1  device select; reads and writes ignored when low.
REQ-007 SHALL have port wstrb  input  1  write strobe.
REQ-008 SHALL have port rstrb  input  1  read strobe; no side effects.
REQ-009 SHALL have port rdata  output  32  read data.
REQ-010 SHALL have port BTN  input  N_BTN  raw asynchronous button pins, active-high.
REQ-011 SHALL have port irq  output  1  level interrupt, high while any flag is set.

Function
REQ-012 SHALL pass each BTN bit through a two-flop synchronizer (sync1, sync2).
REQ-013 SHALL keep a per-button debounced level "stable" and a counter sized to hold DEBOUNCE_CYCLES-1.
REQ-014 SHALL clear the counter on any edge where sync2 equals stable.
REQ-015 SHALL increment the counter on an edge where sync2 differs from stable and count < DEBOUNCE_CYCLES-1.
REQ-016 SHALL load stable from sync2 and clear the counter on the edge where they differ and count == DEBOUNCE_CYCLES-1.
REQ-017 SHALL update stable on the (DEBOUNCE_CYCLES+1)th rising edge after the edge at which sync1 first captures a new level held steady.
REQ-018 SHALL restart the count if the pin reverts before the update, so no glitch shorter than DEBOUNCE_CYCLES reaches stable.
REQ-019 SHALL set press flag[i] on the edge where stable[i] goes 0->1, and release flag[i] on 1->0.
REQ-020 SHALL, when sel && wstrb, clear press flag[i] where wdata[i]=1 and release flag[i] where wdata[4+i]=1 (write-1-to-clear; bits >= N_BTN ignored).
REQ-021 SHALL let set win over clear when both occur on the same edge for the same flag.
REQ-022 SHALL drive rdata combinationally: sel low -> 0; sel high -> [N_BTN-1:0]=stable, [4+N_BTN-1:4]=press flags, [8+N_BTN-1:8]=release flags, all other bits 0.
REQ-023 SHALL drive irq = OR of all press and release flags, from registers with no combinational path from BTN.
REQ-024 SHALL never modify state in response to rstrb.
REQ-025 SHALL handle each button independently; simultaneous edges on multiple buttons set all corresponding flags on the same edge.

Reset
REQ-026 SHALL on reset clear sync1, sync2, stable, counters, press and release flags; rdata = 0 when sel is low; irq = 0.
REQ-027 SHALL, if reset is asserted mid-debounce, discard the partial count with no flag set.
REQ-028 SHALL, after reset with a button already held, debounce normally and then set its press flag.

Structure
REQ-029 SHALL take rdata bit-field offsets (STABLE_LSB=0, PRESS_LSB=4, RELEASE_LSB=8) and the DEBOUNCE_CYCLES default from the shared SoC constants package/header.
REQ-030 SHALL instantiate one sub-module per button, btn_debounce (synchronizer + counter + stable + edge pulses); flags and bus decode stay in button_input.

Verification (DEBOUNCE_CYCLES=4, N_BTN=4)
REQ-031 SHALL check: reset -> stable=0, flags=0, irq=0, rdata=0x00000000 with sel=1.
REQ-032 SHALL check: BTN=0001 held -> stable[0]=1 exactly on the 5th edge after sync1 captures it, press flag 0 set, irq=1, rdata=0x00000011.
REQ-033 SHALL check: BTN[1] pulsed high for 3 cycles -> stable, flags and irq unchanged.
REQ-034 SHALL check: with press flag 0 set, write wdata=0x01 with sel=1, wstrb=1 -> rdata[4]=0, irq=0; the same write with sel=0 has no effect.
REQ-035 SHALL check: release of button 0 coinciding with a wdata=0x10 clear of release flag 0 -> release flag 0 remains 1.
REQ-036 SHALL check: reset asserted 2 cycles into a press -> no flag; after deassertion with the button still held, press flag sets 5 edges after sync1 recaptures it.
